// File: rtl/gpio_cond_pkg.sv
// Shared definitions for the GPIO input conditioner.
//   db_state_e   : per-channel debounce FSM state
//   DB_CYC_DEF   : default number of stable samples that accept a level change
//   IRQ_LEN_DEF  : default interrupt pulse width in clock cycles
package gpio_cond_pkg;

  typedef enum logic [1:0] {
    S_LO = 2'd0,  // stable low
    W_HI = 2'd1,  // low, counting high samples
    S_HI = 2'd2,  // stable high
    W_LO = 2'd3   // high, counting low samples
  } db_state_e;

  localparam int DB_CYC_DEF  = 50000;
  localparam int IRQ_LEN_DEF = 4;

endpackage

// File: rtl/gpio_db_ch.sv
// One conditioned GPIO input channel: 2-flop synchronizer, debounce FSM with
// saturating counter, registered debounced level and an edge-qualified,
// retriggerable interrupt pulse stretcher.
// Ports:
//   clk      : single clock
//   rst      : synchronous active-high reset
//   pad      : raw asynchronous input
//   rise_en  : enable interrupt on debounced rising edge
//   fall_en  : enable interrupt on debounced falling edge
//   db_out   : debounced level (registered)
//   irq_out  : interrupt pulse, IRQ_LEN cycles from the latest qualifying edge
//   state    : current debounce FSM state (debug)
// Handshake: none; all inputs are level signals sampled every clock.
module gpio_db_ch
  import gpio_cond_pkg::*;
#(
  parameter int DB_CYC  = DB_CYC_DEF,
  parameter int IRQ_LEN = IRQ_LEN_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pad,
  input  logic      rise_en,
  input  logic      fall_en,
  output logic      db_out,
  output logic      irq_out,
  output db_state_e state
);

  localparam int CW = $clog2(DB_CYC + 1);
  localparam int IW = $clog2(IRQ_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC);
  localparam logic [IW-1:0] IRQ_MAX = IW'(IRQ_LEN);

  logic [1:0]    sync_q;
  logic          sample;
  db_state_e     state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
  logic          db_q, db_n;
  logic          fire;
  logic [IW-1:0] irq_q, irq_n;

  // sync_q[1] is the only view of the pad the rest of the channel uses.
  assign sample = sync_q[1];

  // Saturating increment: the counter can never wrap past DB_CYC.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      S_LO: begin
        if (sample) begin
          if (DB_CYC == 1) begin
            state_n = S_HI;
            cnt_n   = '0;
          end else begin
            state_n = W_HI;
            cnt_n   = CW'(1);
          end
        end
      end
      W_HI: begin
        if (!sample) begin
          // Any contrary sample restarts the debounce from zero.
          state_n = S_LO;
          cnt_n   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_n = S_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_HI: begin
        if (!sample) begin
          if (DB_CYC == 1) begin
            state_n = S_LO;
            cnt_n   = '0;
          end else begin
            state_n = W_LO;
            cnt_n   = CW'(1);
          end
        end
      end
      W_LO: begin
        if (sample) begin
          state_n = S_HI;
          cnt_n   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_n = S_LO;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = S_LO;
        cnt_n   = '0;
      end
    endcase
  end

  // The level register follows the next state, so DB_OUT changes on the
  // same edge the FSM enters the new stable state.
  assign db_n = (state_n == S_HI) || (state_n == W_LO);

  // Edge detection on the level register; a qualifying edge reloads the
  // pulse counter, which extends an active pulse rather than adding one.
  assign fire  = (db_n & ~db_q & rise_en) | (~db_n & db_q & fall_en);
  assign irq_n = fire             ? IRQ_MAX :
                 (irq_q != '0)    ? irq_q - IW'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      irq_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pad};
      state_q <= state_n;
      cnt_q   <= cnt_n;
      db_q    <= db_n;
      irq_q   <= irq_n;
    end
  end

  assign db_out  = db_q;
  assign irq_out = (irq_q != '0);
  assign state   = state_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: N_CH independent debounce/interrupt channels
// feeding the CM3 core GPIO_IN and INTSIG inputs.
// Ports:
//   CLK_CM3   : single clock (core clock)
//   SYS_RST   : synchronous active-high reset
//   PAD_IN    : raw asynchronous board inputs
//   RISE_EN   : per-channel rising-edge interrupt enable (quasi-static)
//   FALL_EN   : per-channel falling-edge interrupt enable (quasi-static)
//   DB_OUT    : debounced levels
//   IRQ_OUT   : interrupt pulses
//   dbg_state : per-channel debounce FSM state (debug)
// Handshake: none; all signals are levels sampled every clock.
module gpio_in_cond
  import gpio_cond_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int DB_CYC  = DB_CYC_DEF,
  parameter int IRQ_LEN = IRQ_LEN_DEF
) (
  input  logic                  CLK_CM3,
  input  logic                  SYS_RST,
  input  logic [N_CH-1:0]       PAD_IN,
  input  logic [N_CH-1:0]       RISE_EN,
  input  logic [N_CH-1:0]       FALL_EN,
  output logic [N_CH-1:0]       DB_OUT,
  output logic [N_CH-1:0]       IRQ_OUT,
  output logic [N_CH-1:0][1:0]  dbg_state
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_state_e ch_state;

    gpio_db_ch #(
      .DB_CYC  (DB_CYC),
      .IRQ_LEN (IRQ_LEN)
    ) u_ch (
      .clk     (CLK_CM3),
      .rst     (SYS_RST),
      .pad     (PAD_IN[i]),
      .rise_en (RISE_EN[i]),
      .fall_en (FALL_EN[i]),
      .db_out  (DB_OUT[i]),
      .irq_out (IRQ_OUT[i]),
      .state   (ch_state)
    );

    assign dbg_state[i] = ch_state;
  end

endmodule

// File: tb/tb_gpio_in_cond.sv
module tb_gpio_in_cond;
  import gpio_cond_pkg::*;

  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int IL   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_CH-1:0]      pad0, ren0, fen0, db0, irq0;
  logic [N_CH-1:0]      pad1, ren1, fen1, db1, irq1;
  logic [N_CH-1:0][1:0] st0, st1;

  gpio_in_cond #(.N_CH(N_CH), .DB_CYC(DB), .IRQ_LEN(IL)) dut (
    .CLK_CM3(clk), .SYS_RST(rst), .PAD_IN(pad0), .RISE_EN(ren0), .FALL_EN(fen0),
    .DB_OUT(db0), .IRQ_OUT(irq0), .dbg_state(st0)
  );

  gpio_in_cond #(.N_CH(N_CH), .DB_CYC(1), .IRQ_LEN(IL)) dut1 (
    .CLK_CM3(clk), .SYS_RST(rst), .PAD_IN(pad1), .RISE_EN(ren1), .FALL_EN(fen1),
    .DB_OUT(db1), .IRQ_OUT(irq1), .dbg_state(st1)
  );

  // ---------------- reference model ----------------
  // Level view: a channel's accepted level flips once the synchronized input
  // has disagreed with it for DB_CYC consecutive samples; a flip with the
  // matching enable starts (or restarts) an IL-cycle interrupt window.
  logic m_s1  [2][N_CH];
  logic m_s2  [2][N_CH];
  logic m_db  [2][N_CH];
  int   m_run [2][N_CH];
  int   m_irq [2][N_CH];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N_CH; c++) begin
        logic p, re, fe, samp, flip;
        int   need;
        p    = (d == 0) ? pad0[c] : pad1[c];
        re   = (d == 0) ? ren0[c] : ren1[c];
        fe   = (d == 0) ? fen0[c] : fen1[c];
        need = (d == 0) ? DB : 1;
        if (rst) begin
          m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0; m_db[d][c] = 1'b0;
          m_run[d][c] = 0;   m_irq[d][c] = 0;
        end else begin
          samp = m_s2[d][c];
          m_s2[d][c] = m_s1[d][c];
          m_s1[d][c] = p;
          flip = 1'b0;
          if (samp != m_db[d][c]) begin
            m_run[d][c] = m_run[d][c] + 1;
            if (m_run[d][c] >= need) begin
              m_db[d][c]  = samp;
              m_run[d][c] = 0;
              flip = 1'b1;
            end
          end else begin
            m_run[d][c] = 0;
          end
          if (flip && ((m_db[d][c] && re) || (!m_db[d][c] && fe)))
            m_irq[d][c] = IL;
          else if (m_irq[d][c] > 0)
            m_irq[d][c] = m_irq[d][c] - 1;
        end
      end
    end
  end

  function automatic logic [N_CH-1:0] exp_db(int d);
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_db[d][c];
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_irq(int d);
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = (m_irq[d][c] != 0);
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs compared against the model on the falling edge.
  task automatic cyc();
    @(negedge clk);
    cmp("db0_model",  32'(db0),  32'(exp_db(0)));
    cmp("irq0_model", 32'(irq0), 32'(exp_irq(0)));
    cmp("db1_model",  32'(db1),  32'(exp_db(1)));
    cmp("irq1_model", 32'(irq1), 32'(exp_irq(1)));
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  // ---------------- stimulus ----------------
  int hold0 [N_CH];
  int hold1 [N_CH];

  initial begin
    rst = 1'b1;
    pad0 = '0; ren0 = '0; fen0 = '0;
    pad1 = '0; ren1 = '0; fen1 = '0;
    idle(3);
    cmp("rst_db0",  32'(db0),  32'(0));
    cmp("rst_irq0", 32'(irq0), 32'(0));
    cmp("rst_st0",  32'(st0),  32'({N_CH{2'(S_LO)}}));
    rst = 1'b0;
    idle(2);

    // Clean rising edge: level after DB+2 cycles, IL-cycle pulse same cycle.
    ren0[0] = 1'b1;
    pad0[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      cmp("lat_db",  32'(db0[0]),  32'(k >= DB + 2));
      cmp("lat_irq", 32'(irq0[0]), 32'((k >= DB + 2) && (k < DB + 2 + IL)));
    end

    // Glitch of DB-1 cycles is rejected; a DB-cycle high is accepted.
    ren0[1] = 1'b1;
    pad0[1] = 1'b1;
    idle(DB - 1);
    pad0[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      cmp("glitch_db",  32'(db0[1]),  32'(0));
      cmp("glitch_irq", 32'(irq0[1]), 32'(0));
    end
    pad0[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == DB) pad0[1] = 1'b0;
      if (k == DB + 2) cmp("accept_db", 32'(db0[1]), 32'(1));
    end
    idle(6);

    // Fall-only enable: rising edge silent, falling edge pulses.
    fen0[2] = 1'b1;
    pad0[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      cmp("fonly_rise_db",  32'(db0[2]),  32'(k >= DB + 2));
      cmp("fonly_rise_irq", 32'(irq0[2]), 32'(0));
    end
    pad0[2] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      cmp("fonly_fall_db",  32'(db0[2]),  32'(k < DB + 2));
      cmp("fonly_fall_irq", 32'(irq0[2]), 32'((k >= DB + 2) && (k < DB + 2 + IL)));
    end

    // Retrigger (DB_CYC=1): rise then fall one cycle later -> one 1+IL pulse.
    ren1[0] = 1'b1;
    fen1[0] = 1'b1;
    pad1[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) pad1[0] = 1'b0;
      cmp("retrig_db",  32'(db1[0]),  32'(k == 3));
      cmp("retrig_irq", 32'(irq1[0]), 32'((k >= 3) && (k <= 3 + IL)));
    end

    // Reset during the debounce window.
    ren0[3] = 1'b1;
    pad0[3] = 1'b1;
    idle(4);
    cmp("mid_db_state", 32'(st0[3]), 32'(W_HI));
    rst = 1'b1;
    pad0 = '0;
    cyc();
    cmp("rst_w_db",  32'(db0),  32'(0));
    cmp("rst_w_irq", 32'(irq0), 32'(0));
    cmp("rst_w_st",  32'(st0),  32'({N_CH{2'(S_LO)}}));
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      cmp("post_w_irq", 32'(irq0), 32'(0));
      cmp("post_w_db",  32'(db0),  32'(0));
    end

    // Reset during an active pulse.
    pad0[3] = 1'b1;
    idle(DB + 3);
    cmp("pulse_live", 32'(irq0[3]), 32'(1));
    rst = 1'b1;
    pad0 = '0;
    cyc();
    cmp("rst_p_db",  32'(db0),  32'(0));
    cmp("rst_p_irq", 32'(irq0), 32'(0));
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      cmp("post_p_irq", 32'(irq0), 32'(0));
    end

    // All channels rise together.
    ren0 = '1; fen0 = '0; ren1 = '1; fen1 = '0;
    pad0 = '1; pad1 = '1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      cmp("sim_db0",  32'(db0),  32'((k >= DB + 2) ? {N_CH{1'b1}} : {N_CH{1'b0}}));
      cmp("sim_irq0", 32'(irq0), 32'(((k >= DB + 2) && (k < DB + 2 + IL)) ? {N_CH{1'b1}} : {N_CH{1'b0}}));
      cmp("sim_db1",  32'(db1),  32'((k >= 3) ? {N_CH{1'b1}} : {N_CH{1'b0}}));
      cmp("sim_irq1", 32'(irq1), 32'(((k >= 3) && (k < 3 + IL)) ? {N_CH{1'b1}} : {N_CH{1'b0}}));
    end

    // Release from reset with pads held high.
    rst = 1'b1;
    idle(2);
    cmp("hold_rst_db", 32'(db0), 32'(0));
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      cmp("hold_db",  32'(db0),  32'((k >= DB + 2) ? {N_CH{1'b1}} : {N_CH{1'b0}}));
      cmp("hold_irq", 32'(irq0), 32'(((k >= DB + 2) && (k < DB + 2 + IL)) ? {N_CH{1'b1}} : {N_CH{1'b0}}));
    end

    // Randomized phase: random hold times produce both glitches and
    // accepted edges; enables and reset change occasionally.
    for (int c = 0; c < N_CH; c++) begin
      hold0[c] = 0;
      hold1[c] = 0;
    end
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hold0[c] == 0) begin
          pad0[c]  = 1'($urandom_range(0, 1));
          hold0[c] = $urandom_range(1, 9);
        end else begin
          hold0[c]--;
        end
        if (hold1[c] == 0) begin
          pad1[c]  = 1'($urandom_range(0, 1));
          hold1[c] = $urandom_range(0, 4);
        end else begin
          hold1[c]--;
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        ren0 = N_CH'($urandom); fen0 = N_CH'($urandom);
        ren1 = N_CH'($urandom); fen1 = N_CH'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameter N_CH, default 16, which sets the number of conditioned input channels (1..32).
REQ-002 SHALL have parameter DB_CYC, default 50000, which sets the consecutive stable samples required to accept a level change (>=1).
REQ-003 SHALL have parameter IRQ_LEN, default 4, which sets the interrupt pulse width in cycles (>=1).
REQ-004 SHALL have port CLK_CM3, input, width 1: the single clock, the same clock that drives the CM3 core; one clock, no other clock domains.
REQ-005 SHALL have port SYS_RST, input, width 1: reset, synchronous and active-high.
REQ-006 SHALL have port PAD_IN, input, width N_CH: raw asynchronous board inputs (buttons, switches).
REQ-007 SHALL have port RISE_EN, input, width N_CH: per-channel rising-edge interrupt enable, treated as quasi-static.
REQ-008 SHALL have port FALL_EN, input, width N_CH: per-channel falling-edge interrupt enable, treated as quasi-static.
REQ-009 SHALL have port DB_OUT, output, width N_CH: debounced levels, driving the core GPIO_IN low bits.
REQ-010 SHALL have port IRQ_OUT, output, width N_CH: interrupt pulses, driving the core INTSIG.

Function
REQ-011 SHALL pass each PAD_IN bit through a 2-flop synchronizer before any other logic uses it.
REQ-012 SHALL run one independent FSM per channel, with states S_LO, W_HI, S_HI, W_LO, and one counter of width clog2(DB_CYC+1).
REQ-013 SHALL, in S_LO with synced sample 1, set cnt=1 and go to W_HI if DB_CYC>1; if DB_CYC=1, go directly to S_HI.
REQ-014 SHALL, in W_HI, increment cnt on sample 1 and go to S_HI when cnt reaches DB_CYC; on sample 0, go to S_LO and clear cnt.
REQ-015 SHALL make S_HI/W_LO symmetric to S_LO/W_HI with the polarity inverted.
REQ-016 SHALL drive DB_OUT[i] from a register: 1 in S_HI and W_LO, 0 otherwise.
REQ-017 SHALL give a latency from a clean PAD_IN change to DB_OUT change of exactly DB_CYC+2 cycles.
REQ-018 SHALL produce no DB_OUT change for glitches shorter than DB_CYC synced cycles, and SHALL restart the count from zero after every glitch.
REQ-019 SHALL assert IRQ_OUT[i] in the same cycle DB_OUT[i] rises, if RISE_EN[i], or falls, if FALL_EN[i], and hold it for IRQ_LEN cycles.
REQ-020 SHALL, on a new qualifying edge during an active pulse, reload the pulse counter so the pulse extends to IRQ_LEN cycles from the new edge.
REQ-021 SHALL produce no IRQ when an enable is 0 at the edge cycle; clearing an enable mid-pulse does not truncate the pulse.
REQ-022 SHALL keep channels fully independent, including under simultaneous edges on all channels.
REQ-023 SHALL saturate the counter at DB_CYC so it never wraps.

Reset
REQ-024 SHALL, while SYS_RST=1 at a clock edge, clear synchronizers, FSMs (S_LO), counters, DB_OUT and IRQ_OUT to 0.
REQ-025 SHALL, on reset mid-debounce or mid-pulse, abort the operation with no pulse emitted after reset.
REQ-026 SHALL, on release from reset with PAD_IN held high, rise DB_OUT DB_CYC+2 cycles later and, with RISE_EN set, generate an IRQ.

Structure
REQ-027 SHALL place in package gpio_cond_pkg: the state enum (S_LO, W_HI, S_HI, W_LO) and the default constants for DB_CYC and IRQ_LEN.
REQ-028 SHALL implement one channel (synchronizer, FSM, counter, pulse stretcher) in sub-module gpio_db_ch, with the top replicating it N_CH times via generate.

Verification (DB_CYC=4, IRQ_LEN=3, N_CH=4)
REQ-029 SHALL verify a clean edge: PAD_IN[0] 0->1 held, RISE_EN=1 -> DB_OUT[0]=1 exactly 6 cycles later, and IRQ_OUT[0]=1 for exactly 3 cycles starting in that same cycle.
REQ-030 SHALL verify glitch rejection: PAD_IN[1] high for 3 cycles then low -> DB_OUT[1] and IRQ_OUT[1] stay 0; a subsequent 4-cycle high -> DB_OUT[1]=1.
REQ-031 SHALL verify edge filtering: FALL_EN=1 and RISE_EN=0 with a full high-then-low sequence on PAD_IN[2] -> only the falling edge produces a 3-cycle IRQ_OUT[2].
REQ-032 SHALL verify retrigger: both enables set and a debounced fall occurring 1 cycle after a rise pulse starts (DB_CYC=1 build) -> one continuous IRQ_OUT of length 1+3=4 cycles.
REQ-033 SHALL verify reset mid-operation: SYS_RST asserted during W_HI and during an active IRQ pulse -> all outputs 0 the next cycle, and no later spurious pulse.
REQ-034 SHALL verify simultaneous channels: all PAD_IN 0->1 in the same cycle with all RISE_EN=1 -> all DB_OUT and IRQ_OUT bits assert in the same cycle.
